axi_ram_slave: RTL and testbench
================================

# axi_ram_slave

AXI3 responder (slave) modelling a word-addressed on-chip RAM behind the CPU's AXI initiator port. It sits on the SoC side of the CPU's AXI bus (AR/R/AW/W/B channels) and serves simulation and FPGA bring-up. It accepts single-beat and INCR/FIXED bursts with one outstanding read and one outstanding write. Reads and writes share a single-port RAM, and writes have priority.

## Interface

Parameters:
- MEM_AW, 16: word-address width; RAM depth is 2^MEM_AW 32-bit words.
- STALL_SEED, 16'hACE1: LFSR seed, used only with AXI_RAM_STALL_EN.

Ports:
- aclk  in  1  clock; all state changes on rising edge.
- aresetn  in  1  reset; asynchronous, active-low.
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address; arlock/arcache/arprot in 2/4/3, ignored.
- arvalid  in  1 / arready  out  1: AR handshake.
- rid/rdata/rresp/rlast  out  4/32/2/1: read data beat.
- rvalid  out  1 / rready  in  1: R handshake.
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address; awlock/awcache/awprot in 2/4/3, ignored.
- awvalid  in  1 / awready  out  1: AW handshake.
- wid/wdata/wstrb/wlast  in  4/32/4/1: write data; wid ignored.
- wvalid  in  1 / wready  out  1: W handshake.
- bid/bresp  out  4/2: write response.
- bvalid  out  1 / bready  in  1: B handshake.

## Operation

- Word index = addr[MEM_AW+1:2]. Upper address bits alias and raise no error.
- Beat address step is 1<<size for INCR and 0 for FIXED. WRAP (2'b10) is treated as INCR.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch id, addr, len, size, burst; beat counter=0; go to R_FETCH.
  - R_FETCH: issue the RAM read if no write beat is accepted this cycle; otherwise hold. Go to R_DATA next cycle.
  - R_DATA: rvalid=1, rdata registered and stable until handshake. rlast=(cnt==len). On handshake, if last go to R_IDLE; else advance addr, cnt++, go to R_FETCH.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size, burst; cnt=0; err=0; go to W_DATA.
  - W_DATA: wready=1. Each handshake writes the byte lanes enabled by wstrb (wstrb=0 writes nothing), advances addr and cnt.
  - Set err if wlast != (cnt==len). On the beat where cnt==len, go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp = err ? 2'b10 (SLVERR) : 2'b00. On handshake go to W_IDLE.
- rresp is always 2'b00.
- Read and write FSMs run concurrently. RAM conflict: a write beat wins and the read fetch slips one cycle.

## Timing

- Reset: both FSMs to IDLE. arready=awready=1. rvalid=wready=bvalid=rlast=0. rid=bid=0, rdata=0, rresp=bresp=0.
- RAM contents are not reset.
- Read latency: AR handshake at cycle T, rvalid at T+2 (no conflict). Each following beat comes 2 cycles after the previous R handshake. Throughput is 1 beat per 2 cycles.
- Write: first wready at T+1 after the AW handshake. Sustains 1 beat per cycle. bvalid the cycle after the last beat.
- A read issued after a B handshake returns the written data (write completes before bvalid).
- No valid is deasserted without a handshake. Payload outputs are stable while valid && !ready.
- arlen/awlen=0 is a single beat. len=255 is 256 beats; the 8-bit counter does not wrap early.
- Reset asserted mid-burst aborts the transaction at once. No partial response is issued after reset releases.

## Configuration

- AXI_RAM_STALL_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seeded STALL_SEED at reset) steps every cycle.
  - arready, awready and wready are ANDed with !lfsr[0].
  - Entry into R_DATA and W_RESP is delayed while lfsr[1]=1.
  - Protocol rules still hold.
- Undefined: no LFSR; readies and valids exactly as in Operation.

## Structure

- Package axi_ram_pkg: burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/SLVERR), R and W FSM state enums, next-address function.
- Sub-module ram_sp_bytewe: single-port synchronous RAM, 2^MEM_AW x 32, 4 byte write enables, 1-cycle registered read.

## Test plan

- Single write then read: AW addr 0x1000_0010, len 0, wdata 0xDEADBEEF, wstrb 0xF -> bresp 0. AR same addr -> rdata 0xDEADBEEF, rlast=1, rvalid at T+2.
- INCR burst: AW 0x20, len 3, size 2, data 1..4 -> B OKAY. AR 0x20 len 3 -> beats 1,2,3,4, rlast only on the 4th.
- Byte strobes: write 0x11223344 at 0x40, then wdata 0xAABBCCDD with wstrb 0x5 -> read returns 0x11BB33DD.
- Early wlast: AW len 2, wlast on beat 0 -> bresp 2'b10, bid=awid, FSM returns to W_IDLE.
- Backpressure and conflict: rready low for 5 cycles -> rdata/rlast stable. A read fetch coincident with a write beat -> rvalid slips one cycle, data correct.
- Reset pulse mid read burst (beat 2 of 4) -> rvalid=0 and arready=1 immediately; a new AR after release is served normally.

Source files
------------

// File: rtl/axi_ram_pkg.sv
// Shared encodings, FSM states and address helper for axi_ram_slave.
// Imported by the RAM responder top and its storage sub-module.
package axi_ram_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  // WRAP is deliberately handled like INCR.
  function automatic logic [31:0] next_addr(
    input logic [31:0] addr,
    input logic [2:0]  size,
    input logic [1:0]  burst
  );
    if (burst == BURST_FIXED) return addr;
    return addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/ram_sp_bytewe.sv
// Single-port synchronous RAM, 2^AW x 32, byte write enables, registered read.
// Ports: clk_i, rst_ni (read register only), re_i, we_i[3:0], addr_i, wdata_i, rdata_o.
module ram_sp_bytewe #(
  parameter int AW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          re_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  // Output only changes on a read, so it holds while a beat is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 RAM responder: one outstanding read and write, INCR/FIXED bursts.
// Ports: aclk/aresetn, AR/R/AW/W/B channels. Option: AXI_RAM_STALL_EN.
module axi_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int          MEM_AW     = 16,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  r_state_e    r_state_q, r_state_d;
  logic [3:0]  rid_q, rid_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d;

  w_state_e    w_state_q, w_state_d;
  logic [3:0]  bid_q, bid_d;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;
  logic        werr_q, werr_d;
  logic        wdone_q, wdone_d;

  logic        stall_rdy, stall_val;
  logic        w_fire, r_re;
  logic [3:0]  ram_we;

`ifdef AXI_RAM_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr_q <= STALL_SEED;
    else lfsr_q <= {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall_rdy = lfsr_q[0];
  assign stall_val = lfsr_q[1];
`else
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
  assign stall_rdy   = 1'b0;
  assign stall_val   = 1'b0;
`endif

  assign arready = (r_state_q == R_IDLE) && !stall_rdy;
  assign awready = (w_state_q == W_IDLE) && !stall_rdy;
  assign wready  = (w_state_q == W_DATA) && !wdone_q && !stall_rdy;
  assign w_fire  = wvalid && wready;
  assign ram_we  = w_fire ? wstrb : 4'h0;
  // The write beat owns the single RAM port; the fetch retries next cycle.
  assign r_re    = (r_state_q == R_FETCH) && !w_fire;

  assign rvalid = (r_state_q == R_DATA);
  assign rlast  = rvalid && (rcnt_q == rlen_q);
  assign rid    = rid_q;
  assign rresp  = RESP_OKAY;
  assign bvalid = (w_state_q == W_RESP);
  assign bid    = bid_q;
  assign bresp  = (bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;

  ram_sp_bytewe #(.AW(MEM_AW)) u_ram (
    .clk_i   (aclk),
    .rst_ni  (aresetn),
    .re_i    (r_re),
    .we_i    (ram_we),
    .addr_i  (w_fire ? waddr_q[MEM_AW+1:2] : raddr_q[MEM_AW+1:2]),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    unique case (r_state_q)
      R_IDLE: if (arvalid && arready) begin
        rid_d     = arid;
        raddr_d   = araddr;
        rlen_d    = arlen;
        rsize_d   = arsize;
        rburst_d  = arburst;
        rcnt_d    = 8'd0;
        r_state_d = R_FETCH;
      end
      R_FETCH: if (r_re && !stall_val) r_state_d = R_DATA;
      R_DATA: if (rready) begin
        if (rcnt_q == rlen_q) begin
          r_state_d = R_IDLE;
        end else begin
          raddr_d   = next_addr(raddr_q, rsize_q, rburst_q);
          rcnt_d    = rcnt_q + 8'd1;
          r_state_d = R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    wdone_d   = wdone_q;
    unique case (w_state_q)
      W_IDLE: if (awvalid && awready) begin
        bid_d     = awid;
        waddr_d   = awaddr;
        wlen_d    = awlen;
        wsize_d   = awsize;
        wburst_d  = awburst;
        wcnt_d    = 8'd0;
        werr_d    = 1'b0;
        wdone_d   = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: begin
        if (w_fire) begin
          werr_d = werr_q | (wlast != (wcnt_q == wlen_q));
          if (wcnt_q == wlen_q) begin
            if (stall_val) wdone_d = 1'b1;
            else w_state_d = W_RESP;
          end else begin
            waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
            wcnt_d  = wcnt_q + 8'd1;
          end
        end else if (wdone_q && !stall_val) begin
          wdone_d   = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      w_state_q <= W_IDLE;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      wdone_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      wdone_q   <= wdone_d;
    end
  end

  // Sideband and aliased address bits carry no function here.
  logic unused_bits;
  assign unused_bits = ^{arlock, arcache, arprot, awlock, awcache,
                         awprot, wid, raddr_q[31:MEM_AW+2],
                         raddr_q[1:0], waddr_q[31:MEM_AW+2],
                         waddr_q[1:0]};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave.
// Drives and samples on the falling clock edge.
module tb_axi_ram_slave;
  import axi_ram_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, awvalid, wvalid, wlast, rready, bready;
  logic        arready, awready, wready, rvalid, rlast, bvalid;
  logic [3:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  axi_ram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache),
    .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic do_aw(input logic [3:0] id, input logic [31:0] a,
                       input logic [7:0] len, input logic [1:0] bu);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awsize = 3'd2; awburst = bu;
    awvalid = 1'b1;
    while (!awready && n < 20) begin @(negedge aclk); n++; end
    total++;
    if (!awready) begin bad++; $display("FAIL aw_timeout got=0 want=1"); end
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] a,
                       input logic [7:0] len, input logic [1:0] bu);
    int n = 0;
    arid = id; araddr = a; arlen = len; arsize = 3'd2; arburst = bu;
    arvalid = 1'b1;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    total++;
    if (!arready) begin bad++; $display("FAIL ar_timeout got=0 want=1"); end
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s,
                        input logic l);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && n < 20) begin @(negedge aclk); n++; end
    total++;
    if (!wready) begin bad++; $display("FAIL w_timeout got=0 want=1"); end
    @(negedge aclk);
  endtask

  task automatic b_get(output logic [1:0] resp, output logic [3:0] id);
    int n = 0;
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    total++;
    if (!bvalid) begin bad++; $display("FAIL b_timeout got=0 want=1"); end
    resp = bresp; id = bid; bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic r_get(output logic [31:0] d, output logic l,
                       output logic [3:0] id, output int waited);
    waited = 0;
    while (!rvalid && waited < 20) begin @(negedge aclk); waited++; end
    total++;
    if (!rvalid) begin bad++; $display("FAIL r_timeout got=0 want=1"); end
    d = rdata; l = rlast; id = rid; rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    total++;
    if ({arready, awready, rvalid, wready, bvalid, rlast} !== 6'b110000) begin
      bad++;
      $display("FAIL rst_hs got=%b want=110000",
               {arready, awready, rvalid, wready, bvalid, rlast});
    end
    total++;
    if ({rid, bid, rdata, rresp, bresp} !== 44'h0) begin
      bad++;
      $display("FAIL rst_payload got=%h want=0", {rid, bid, rdata, rresp, bresp});
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_single;
    logic [1:0] r; logic [3:0] id; logic [31:0] d; logic l; int w;
    do_aw(4'd3, 32'h1000_0010, 8'd0, BURST_INCR);
    w_beat(32'hDEAD_BEEF, 4'hF, 1'b1);
    wvalid = 1'b0;
    b_get(r, id);
    total++;
    if (r !== 2'b00 || id !== 4'd3) begin
      bad++; $display("FAIL single_b got=%b/%0d want=00/3", r, id);
    end
    do_ar(4'd5, 32'h1000_0010, 8'd0, BURST_INCR);
    r_get(d, l, id, w);
    total++;
    if (d !== 32'hDEAD_BEEF || l !== 1'b1 || id !== 4'd5 || w != 1) begin
      bad++;
      $display("FAIL single_r got=%h/%b/%0d/%0d want=deadbeef/1/5/1", d, l, id, w);
    end
    do_ar(4'd6, 32'h0000_0010, 8'd0, BURST_INCR);
    r_get(d, l, id, w);
    total++;
    if (d !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL alias got=%h want=deadbeef", d);
    end
  endtask

  task automatic test_incr_burst;
    logic [1:0] r; logic [3:0] id; logic [31:0] d; logic l; int w;
    do_aw(4'd1, 32'h20, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++) w_beat(32'(i + 1), 4'hF, i == 3);
    wvalid = 1'b0;
    b_get(r, id);
    total++;
    if (r !== 2'b00 || id !== 4'd1) begin
      bad++; $display("FAIL incr_b got=%b/%0d want=00/1", r, id);
    end
    do_ar(4'd2, 32'h20, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++) begin
      r_get(d, l, id, w);
      total++;
      if (d !== 32'(i + 1) || l !== (i == 3) || w != 1) begin
        bad++;
        $display("FAIL incr_r%0d got=%h/%b/%0d want=%h/%b/1", i, d, l, w,
                 32'(i + 1), (i == 3));
      end
    end
    do_aw(4'd4, 32'h80, 8'd1, BURST_FIXED);
    w_beat(32'h0000_000A, 4'hF, 1'b0);
    w_beat(32'h0000_000B, 4'hF, 1'b1);
    wvalid = 1'b0;
    b_get(r, id);
    do_ar(4'd4, 32'h80, 8'd0, BURST_INCR);
    r_get(d, l, id, w);
    total++;
    if (d !== 32'h0000_000B || r !== 2'b00) begin
      bad++; $display("FAIL fixed got=%h/%b want=0000000b/00", d, r);
    end
  endtask

  task automatic test_strobe;
    logic [1:0] r; logic [3:0] id; logic [31:0] d; logic l; int w;
    do_aw(4'd0, 32'h40, 8'd0, BURST_INCR);
    w_beat(32'h1122_3344, 4'hF, 1'b1);
    wvalid = 1'b0;
    b_get(r, id);
    do_aw(4'd0, 32'h40, 8'd0, BURST_INCR);
    w_beat(32'hAABB_CCDD, 4'h5, 1'b1);
    wvalid = 1'b0;
    b_get(r, id);
    do_ar(4'd0, 32'h40, 8'd0, BURST_INCR);
    r_get(d, l, id, w);
    total++;
    if (d !== 32'h11BB_33DD) begin
      bad++; $display("FAIL strobe got=%h want=11bb33dd", d);
    end
    do_aw(4'd0, 32'h40, 8'd0, BURST_INCR);
    w_beat(32'hFFFF_FFFF, 4'h0, 1'b1);
    wvalid = 1'b0;
    b_get(r, id);
    do_ar(4'd0, 32'h40, 8'd0, BURST_INCR);
    r_get(d, l, id, w);
    total++;
    if (d !== 32'h11BB_33DD) begin
      bad++; $display("FAIL strobe0 got=%h want=11bb33dd", d);
    end
  endtask

  task automatic test_early_wlast;
    logic [1:0] r; logic [3:0] id;
    do_aw(4'd9, 32'h60, 8'd2, BURST_INCR);
    w_beat(32'h1, 4'hF, 1'b1);
    total++;
    if (wready !== 1'b1 || bvalid !== 1'b0) begin
      bad++; $display("FAIL early_mid got=%b%b want=10", wready, bvalid);
    end
    w_beat(32'h2, 4'hF, 1'b0);
    w_beat(32'h3, 4'hF, 1'b1);
    wvalid = 1'b0;
    b_get(r, id);
    total++;
    if (r !== 2'b10 || id !== 4'd9) begin
      bad++; $display("FAIL early_b got=%b/%0d want=10/9", r, id);
    end
    total++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      bad++; $display("FAIL early_idle got=%b%b want=10", awready, bvalid);
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] id; logic [31:0] d; logic l; int w;
    do_ar(4'd7, 32'h20, 8'd1, BURST_INCR);
    @(negedge aclk);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rvalid !== 1'b1 || rdata !== 32'h1 || rlast !== 1'b0) begin
        bad++;
        $display("FAIL hold%0d got=%b/%h/%b want=1/00000001/0", i, rvalid, rdata, rlast);
      end
      @(negedge aclk);
    end
    r_get(d, l, id, w);
    r_get(d, l, id, w);
    total++;
    if (d !== 32'h2 || l !== 1'b1 || id !== 4'd7) begin
      bad++; $display("FAIL bp_last got=%h/%b/%0d want=00000002/1/7", d, l, id);
    end
  endtask

  task automatic test_conflict;
    logic [1:0] r; logic [3:0] id; logic [31:0] d; logic l; int w;
    arid = 4'd2; araddr = 32'h20; arlen = 8'd0; arsize = 3'd2;
    arburst = BURST_INCR; arvalid = 1'b1;
    awid = 4'd8; awaddr = 32'hC0; awlen = 8'd0; awsize = 3'd2;
    awburst = BURST_INCR; awvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0; awvalid = 1'b0;
    wdata = 32'h5A5A_0001; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    total++;
    if (rvalid !== 1'b0) begin
      bad++; $display("FAIL slip got=%b want=0", rvalid);
    end
    @(negedge aclk);
    total++;
    if (rvalid !== 1'b1 || rdata !== 32'h1) begin
      bad++; $display("FAIL slip_data got=%b/%h want=1/00000001", rvalid, rdata);
    end
    r_get(d, l, id, w);
    b_get(r, id);
    total++;
    if (r !== 2'b00 || id !== 4'd8) begin
      bad++; $display("FAIL conf_b got=%b/%0d want=00/8", r, id);
    end
    do_ar(4'd0, 32'hC0, 8'd0, BURST_INCR);
    r_get(d, l, id, w);
    total++;
    if (d !== 32'h5A5A_0001) begin
      bad++; $display("FAIL conf_wr got=%h want=5a5a0001", d);
    end
  endtask

  task automatic test_long_burst;
    logic [1:0] r; logic [3:0] id; logic [31:0] d; logic l; int w;
    int errs = 0;
    do_aw(4'd6, 32'h400, 8'd255, BURST_INCR);
    for (int i = 0; i < 256; i++) w_beat(32'(i * 3), 4'hF, i == 255);
    wvalid = 1'b0;
    b_get(r, id);
    total++;
    if (r !== 2'b00) begin
      bad++; $display("FAIL long_b got=%b want=00", r);
    end
    do_ar(4'd6, 32'h400, 8'd255, BURST_INCR);
    for (int i = 0; i < 256; i++) begin
      r_get(d, l, id, w);
      if (d !== 32'(i * 3) || l !== (i == 255)) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL long_r got=%0d bad beats want=0", errs);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] id; logic [31:0] d; logic l; int w; int n = 0;
    do_ar(4'd3, 32'h20, 8'd3, BURST_INCR);
    r_get(d, l, id, w);
    r_get(d, l, id, w);
    while (!rvalid && n < 20) begin @(negedge aclk); n++; end
    aresetn = 1'b0;
    #1;
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0) begin
      bad++; $display("FAIL mid_rst got=%b%b%b want=010", rvalid, arready, rlast);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      bad++; $display("FAIL post_rst got=%b%b want=01", rvalid, arready);
    end
    do_ar(4'd1, 32'h40, 8'd0, BURST_INCR);
    r_get(d, l, id, w);
    total++;
    if (d !== 32'h11BB_33DD || l !== 1'b1 || w != 1 || id !== 4'd1) begin
      bad++;
      $display("FAIL after_rst got=%h/%b/%0d/%0d want=11bb33dd/1/1/1", d, l, w, id);
    end
  endtask

  initial begin
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    test_reset();
    test_single();
    test_incr_burst();
    test_strobe();
    test_early_wlast();
    test_backpressure();
    test_conflict();
    test_long_burst();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
